// File: rtl/serial_regbus_bridge.sv
// Serial command slave: debounces the two-wire SDa/SCl link, decodes framed write/read
// commands onto the register bus and shifts status plus read data back on RDa.
module serial_regbus_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEB_LEN = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              SDa,
  input  logic              SCl,
  output logic              RDa,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] rdata,
  output logic              wr,
  output logic              rd,
  input  logic              ack,
  input  logic              nack,
  input  logic              unknown,
  output logic              timeout,
  output logic              frame_err,
  output logic              busy
);
  localparam int RX_W = ADDR_W + DATA_W;
  localparam int BC_W = $clog2(1 + ADDR_W + DATA_W);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int TX_W = 2 + DATA_W;
  localparam int TC_W = $clog2(TX_W + 2);
  localparam int DC_W = $clog2(DEB_LEN);
  localparam logic [1:0] PEND_NONE  = 2'd0;
  localparam logic [1:0] PEND_STOP  = 2'd1;
  localparam logic [1:0] PEND_START = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, BUS = 2'd2, TX = 2'd3} state_e;
  state_e state_q, state_d;

  // Bit 0 carries SDa, bit 1 carries SCl.
  logic [1:0]            sync1_q, sync2_q, filt_q, prev_q;
  logic [1:0][DC_W-1:0]  deb_cnt_q;
  logic                  start_s, stop_s, rise_s, fall_s;
  logic [BC_W-1:0]       rx_cnt_q;
  logic [BC_W:0]         rx_next_cnt_s, rx_len_s;
  logic                  rx_w_s, rx_last_s, rx_clr_s, w_q;
  logic [RX_W-1:0]       rx_sr_q, rx_sr_s;
  logic [TO_W-1:0]       to_cnt_q;
  logic                  to_hit_s, bus_end_s;
  logic [1:0]            status_s, pend_q, pend_s;
  logic [DATA_W-1:0]     rdcap_s;
  logic [TX_W-1:0]       tx_sr_q;
  logic [TC_W-1:0]       tx_cnt_q, tx_len_s;
  logic                  txrd_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic                  rda_q, rda_d, wr_q, wr_d, rd_q, rd_d;
  logic                  timeout_q, timeout_d, ferr_q, ferr_d, busy_q, busy_d;

  // Two-flop synchroniser plus run-length filter on both raw lines.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      prev_q    <= 2'b11;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= {SCl, SDa};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DC_W'(DEB_LEN - 1)) begin
          filt_q[i]    <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Line events, frame length and bus-termination decode.
  always_comb begin
    start_s       = prev_q[0] & ~filt_q[0] & filt_q[1];
    stop_s        = ~prev_q[0] & filt_q[0] & filt_q[1];
    rise_s        = ~prev_q[1] & filt_q[1];
    fall_s        = prev_q[1] & ~filt_q[1];
    rx_sr_s       = {rx_sr_q[RX_W-2:0], filt_q[0]};
    rx_next_cnt_s = {1'b0, rx_cnt_q} + 1'b1;
    rx_w_s        = (rx_cnt_q == '0) ? filt_q[0] : w_q;
    rx_len_s      = rx_w_s ? (BC_W+1)'(1 + RX_W) : (BC_W+1)'(1 + ADDR_W);
    rx_last_s     = (rx_next_cnt_s == rx_len_s);
    to_hit_s      = (to_cnt_q == TO_W'(TIMEOUT));
    bus_end_s     = (state_q == BUS) & (wr_q | rd_q) & (ack | nack | unknown | to_hit_s);
    tx_len_s      = txrd_q ? TC_W'(TX_W) : TC_W'(2);
    pend_s        = start_s ? PEND_START : (stop_s ? PEND_STOP : pend_q);
  end

  // Status encoding with ack > nack > unknown > timeout priority.
  always_comb begin
    status_s = 2'b11;
    rdcap_s  = {DATA_W{1'b0}};
    if (ack) begin
      status_s = 2'b00;
    end else if (nack) begin
      status_s = 2'b01;
    end else if (unknown) begin
      status_s = 2'b10;
    end else begin
      status_s = 2'b11;
    end
    if (rd_q && (status_s == 2'b00)) begin
      rdcap_s = rdata;
    end else begin
      rdcap_s = {DATA_W{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a START or STOP seen during BUS only acts once the bus cycle ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) state_d = RX;
        else         state_d = IDLE;
      end
      RX: begin
        if (start_s)                 state_d = RX;
        else if (stop_s)             state_d = IDLE;
        else if (rise_s && rx_last_s) state_d = BUS;
        else                         state_d = RX;
      end
      BUS: begin
        if (!bus_end_s)                 state_d = BUS;
        else if (pend_s == PEND_START)  state_d = RX;
        else if (pend_s == PEND_STOP)   state_d = IDLE;
        else                            state_d = TX;
      end
      TX: begin
        if (start_s)     state_d = RX;
        else if (stop_s) state_d = IDLE;
        else             state_d = TX;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_clr_s = (state_d == RX) & ((state_q != RX) | start_s);

  // Output next-values; RDa only leaves 1 while response bits are being shifted.
  always_comb begin
    rda_d     = 1'b1;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    timeout_d = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = (state_d != IDLE);
    case (state_q)
      RX: begin
        if (stop_s && !start_s) ferr_d = 1'b1;
        else                    ferr_d = 1'b0;
      end
      BUS: begin
        if (bus_end_s) begin
          timeout_d = (status_s == 2'b11);
        end else begin
          wr_d = w_q;
          rd_d = ~w_q;
        end
      end
      TX: begin
        if (start_s || stop_s)                       rda_d = 1'b1;
        else if (fall_s && (tx_cnt_q < tx_len_s))    rda_d = tx_sr_q[TX_W-1];
        else if (fall_s)                             rda_d = 1'b1;
        else                                         rda_d = rda_q;
        if (rise_s && (tx_cnt_q > tx_len_s)) ferr_d = 1'b1;
        else                                 ferr_d = 1'b0;
      end
      default: rda_d = 1'b1;
    endcase
  end

  // Receive shifter, bus wait counter and response shifter.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rx_cnt_q <= '0;
      rx_sr_q  <= '0;
      w_q      <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      to_cnt_q <= '0;
      pend_q   <= PEND_NONE;
      tx_sr_q  <= '0;
      tx_cnt_q <= '0;
      txrd_q   <= 1'b0;
    end else begin
      if (rx_clr_s) begin
        rx_cnt_q <= '0;
        w_q      <= 1'b0;
      end else if ((state_q == RX) && rise_s) begin
        rx_cnt_q <= rx_next_cnt_s[BC_W-1:0];
        rx_sr_q  <= rx_sr_s;
        w_q      <= rx_w_s;
        if (rx_last_s && rx_w_s) begin
          addr_q <= rx_sr_s[RX_W-1:DATA_W];
          data_q <= rx_sr_s[DATA_W-1:0];
        end else if (rx_last_s) begin
          addr_q <= rx_sr_s[ADDR_W-1:0];
        end
      end
      if (state_q != BUS) begin
        to_cnt_q <= '0;
      end else if ((wr_q | rd_q) && !to_hit_s) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      pend_q <= (state_q == BUS) ? pend_s : PEND_NONE;
      if (bus_end_s) begin
        tx_sr_q  <= {status_s, rdcap_s};
        txrd_q   <= rd_q;
        tx_cnt_q <= '0;
      end else if ((state_q == TX) && fall_s && (tx_cnt_q <= tx_len_s)) begin
        tx_sr_q  <= {tx_sr_q[TX_W-2:0], 1'b0};
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rda_q     <= 1'b1;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      timeout_q <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rda_q     <= rda_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      timeout_q <= timeout_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign RDa       = rda_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign timeout   = timeout_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
  assign addr      = addr_q;
  assign data      = data_q;

endmodule

// File: doc/serial_regbus_bridge.md
Name: serial_regbus_bridge

Overview:
- Parametrised next-generation serial command slave.
- Debounces the two-wire serial link (SDa data, SCl clock) and decodes framed write/read commands.
- Drives the internal register bus (addr/data/wr/rd, ack/nack/unknown) and shifts status plus read data back on RDa.
- Adds configurable address/data width, configurable debounce depth, a bus timeout with status reporting, and frame-error detection.
- Sits between the board test-header pins and the TDC register file.

Parameters:
- ADDR_W, 16: register address width in bits.
- DATA_W, 32: register data width in bits.
- DEB_LEN, 4: consecutive identical clk samples required to accept a new SDa/SCl level (≥2).
- TIMEOUT, 255: clk cycles allowed for ack/nack/unknown before the bridge declares a timeout (≥1).

Ports:
- clk  in  1  bridge/register-bus clock
- reset_i  in  1  asynchronous, active-low reset
- SDa  in  1  raw serial data line
- SCl  in  1  raw serial clock line
- RDa  out  1  return serial data
- addr  out  ADDR_W  register address
- data  out  DATA_W  write data to register file
- rdata  in  DATA_W  read data from register file
- wr  out  1  write strobe, level until terminated
- rd  out  1  read strobe, level until terminated
- ack  in  1  transaction accepted
- nack  in  1  transaction refused
- unknown  in  1  address not decoded
- timeout  out  1  one-clk pulse when the bus times out
- frame_err  out  1  one-clk pulse on an aborted or over-long frame
- busy  out  1  high from frame start until the response is fully shifted or aborted

Behaviour:
- Reset: asynchronous, active-low on reset_i. All outputs go to 0 except RDa=1. State returns to IDLE and all shift registers and counters clear. Reset mid-transaction abandons it silently.
- Debounce: 2-flop synchroniser per line, then a counter. The filtered level changes only after DEB_LEN equal samples. Input-to-filtered latency is 2+DEB_LEN clks. All edges below refer to the filtered lines.
- START: SDa falls while SCl=1. STOP: SDa rises while SCl=1. Bits are sampled on SCl rising edges. The bridge changes RDa on SCl falling edges.
- Frame, MSB first:
  - 1 bit W (1=write, 0=read).
  - ADDR_W address bits.
  - If W=1, DATA_W data bits.
- States:
  - IDLE: wait for START, then go to RX (busy=1).
  - RX: shift bits. After the last expected bit, load addr (and data for a write) and go to BUS.
  - BUS: assert wr or rd on the next clk and hold it. Terminate on the first clk where any of ack/nack/unknown is high, or when the wait counter reaches TIMEOUT. Deassert wr/rd on the following clk.
    - Status priority when inputs coincide: ack > nack > unknown.
    - Status code: ack=00, nack=01, unknown=10, timeout=11.
    - On a timeout, pulse the timeout output for one clk.
    - On a read that ends in ack, capture rdata into the TX shift register. Any other result loads zeros.
    - Go to TX.
  - TX: on successive SCl falling edges drive RDa with 2 status bits, then DATA_W read bits (read only). After the last bit, RDa=1 and the state waits for STOP, then goes to IDLE with busy=0.
  - RDa=1 at all times outside TX. Before TX is entered, RDa=1, which tells the master "not ready". Masters wait ≥2+DEB_LEN+TIMEOUT+3 clks before clocking the response.
- Boundary conditions:
  - STOP during RX: pulse frame_err, no bus cycle, go to IDLE.
  - STOP during BUS or TX: finish the bus cycle, discard the remaining response, go to IDLE.
  - START in any state except BUS: restart RX and clear counters.
  - START during BUS: deferred until BUS exits.
  - Extra SCl rising edges in TX after the last bit: pulse frame_err, RDa stays 1.
  - Bit counter width is clog2(1+ADDR_W+DATA_W). Timeout counter width is clog2(TIMEOUT+1) and saturates, never wraps.
  - addr/data hold their last values after the transaction.

Test Plan:
- Write with defaults: START, W=1, addr 0x0012, data 0xDEADBEEF, ack after 3 clks. Required: wr high 4 clks, addr=0x0012, data=0xDEADBEEF; RDa returns 00; timeout=0, frame_err=0.
- Read: W=0, addr 0x0100, rdata=0x12345678, ack after 1 clk. Required: rd high 2 clks; RDa shifts 00, then 0x12345678 MSB first; busy falls after STOP.
- Timeout: write with ack/nack/unknown never asserted, TIMEOUT=255. Required: wr high exactly 256 clks, one timeout pulse, status 11.
- Coincident status: ack and unknown high on the same clk. Required: status 00. Separately, unknown alone gives status 10 and read data shifts as all zeros.
- Glitch and abort: SCl pulse of DEB_LEN-1 clks is ignored, with no bit counted. STOP after 5 address bits gives one frame_err pulse, wr=rd=0, state IDLE.
- Reset mid-read: reset_i low during BUS with rd=1. Required: rd=0 and RDa=1 immediately (asynchronous), busy=0. The next frame decodes normally.
